// File: rtl/ttt_pkg.sv
// ttt_pkg
//   Shared encodings for the tic-tac-toe game sequencer: cell and result
//   codes, the controller state enum, the winning-line table and the
//   cell-to-bit-position helper.
package ttt_pkg;

  // Contents of one board cell.
  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_X     = 2'b01,
    CELL_O     = 2'b10
  } cell_t;

  // Game outcome as published on the result port.
  typedef enum logic [1:0] {
    RES_PLAY = 2'b00,
    RES_XWIN = 2'b01,
    RES_OWIN = 2'b10,
    RES_DRAW = 2'b11
  } result_t;

  // Controller states.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_KEY = 3'd1,
    S_PLACE    = 3'd2,
    S_CHECK    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam int unsigned NUM_LINES = 8;

  // Winning lines as cell-index triples. Entry i holds {c0, c1, c2} with
  // c0 in nibble [2]; the concatenation lists line 7 first so that
  // LINE_TBL[i] is line i.
  localparam logic [7:0][2:0][3:0] LINE_TBL = {
    12'h357,  // 7: 3-5-7
    12'h159,  // 6: 1-5-9
    12'h369,  // 5: 3-6-9
    12'h258,  // 4: 2-5-8
    12'h147,  // 3: 1-4-7
    12'h789,  // 2: 7-8-9
    12'h456,  // 1: 4-5-6
    12'h123   // 0: 1-2-3
  };

  // LSB position of cell k (1..9) in the 18-bit board: cell k occupies
  // bits [19-2k:18-2k]. Callers must only pass k in 1..9.
  function automatic logic [4:0] cell_bits(input logic [3:0] k);
    return 5'd18 - {k, 1'b0};
  endfunction

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// ttt_game_ctrl_if
//   Key handshake between the keypad scanner and the game sequencer.
//   key_valid : one-cycle strobe, key_code valid this cycle
//   key_code  : key value, 1..9 are cells
//   key_ready : sequencer will accept a key this cycle
//   master = keypad scanner side, slave = game sequencer side.
interface ttt_game_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/ttt_game_ctrl_line_check.sv
// ttt_line_check
//   Combinational test of one winning line against the mover's code.
//   i_board    : 18-bit board, cell k at [19-2k:18-2k]
//   i_line_idx : line index 0..7 into LINE_TBL
//   i_mover    : code of the player who just moved
//   o_match    : all three cells of the line hold i_mover
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] i_board,
  input  logic [2:0]  i_line_idx,
  input  cell_t       i_mover,
  output logic        o_match
);

  logic [3:0] w_c0, w_c1, w_c2;
  logic [1:0] w_v0, w_v1, w_v2;

  always_comb begin
    w_c0 = LINE_TBL[i_line_idx][2];
    w_c1 = LINE_TBL[i_line_idx][1];
    w_c2 = LINE_TBL[i_line_idx][0];
    w_v0 = i_board[cell_bits(w_c0) +: 2];
    w_v1 = i_board[cell_bits(w_c1) +: 2];
    w_v2 = i_board[cell_bits(w_c2) +: 2];
    o_match = (w_v0 == i_mover) && (w_v1 == i_mover) && (w_v2 == i_mover);
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl
//   Tic-tac-toe game sequencer. Accepts keypad moves, validates and places
//   them, then scans the eight winning lines one per cycle and publishes
//   turn and result.
//   clk      : system clock
//   rst      : synchronous active-low reset
//   play_en  : 1 = game mode; 0 clears the game and holds IDLE
//   key_if   : key handshake (slave side)
//   board    : 18-bit board, cell k at [19-2k:18-2k]
//   turn_o   : 0 = X to move, 1 = O to move
//   result   : 00 playing, 01 X wins, 10 O wins, 11 draw
//   win_line : winning line index, valid on a win
//   move_cnt : stones placed, 0..9
//   reject   : one-cycle pulse for an invalid or occupied-cell key
module ttt_game_ctrl
  import ttt_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    play_en,
  ttt_game_ctrl_if.slave          key_if,
  output logic [17:0]             board,
  output logic                    turn_o,
  output logic [1:0]              result,
  output logic [2:0]              win_line,
  output logic [3:0]              move_cnt,
  output logic                    reject
);

  state_t      r_state,    w_state_nxt;
  logic [17:0] r_board,    w_board_nxt;
  logic        r_turn,     w_turn_nxt;
  result_t     r_result,   w_result_nxt;
  logic [2:0]  r_win_line, w_win_line_nxt;
  logic [3:0]  r_move_cnt, w_move_cnt_nxt;
  logic        r_reject,   w_reject_nxt;
  logic [2:0]  r_line_idx, w_line_idx_nxt;
  logic [3:0]  r_cell,     w_cell_nxt;

  cell_t       w_mover;
  logic        w_match;
  logic        w_code_in_range;
  logic [3:0]  w_code_safe;
  logic        w_cell_empty;

  assign w_mover = r_turn ? CELL_O : CELL_X;

  ttt_line_check u_line_check (
    .i_board    (r_board),
    .i_line_idx (r_line_idx),
    .i_mover    (w_mover),
    .o_match    (w_match)
  );

  // Out-of-range codes are redirected to cell 1 only to keep the board
  // lookup in bounds; they are rejected regardless of that cell's contents.
  assign w_code_in_range = (key_if.key_code >= 4'd1) && (key_if.key_code <= 4'd9);
  assign w_code_safe     = w_code_in_range ? key_if.key_code : 4'd1;
  assign w_cell_empty    = (r_board[cell_bits(w_code_safe) +: 2] == CELL_EMPTY);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_board    <= '0;
      r_turn     <= 1'b0;
      r_result   <= RES_PLAY;
      r_win_line <= '0;
      r_move_cnt <= '0;
      r_reject   <= 1'b0;
      r_line_idx <= '0;
      r_cell     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_board    <= w_board_nxt;
      r_turn     <= w_turn_nxt;
      r_result   <= w_result_nxt;
      r_win_line <= w_win_line_nxt;
      r_move_cnt <= w_move_cnt_nxt;
      r_reject   <= w_reject_nxt;
      r_line_idx <= w_line_idx_nxt;
      r_cell     <= w_cell_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_board_nxt    = r_board;
    w_turn_nxt     = r_turn;
    w_result_nxt   = r_result;
    w_win_line_nxt = r_win_line;
    w_move_cnt_nxt = r_move_cnt;
    w_reject_nxt   = 1'b0;
    w_line_idx_nxt = r_line_idx;
    w_cell_nxt     = r_cell;

    if (!play_en) begin
      // Leaving game mode clears the game from any state, including CHECK.
      w_state_nxt    = S_IDLE;
      w_board_nxt    = '0;
      w_turn_nxt     = 1'b0;
      w_result_nxt   = RES_PLAY;
      w_win_line_nxt = '0;
      w_move_cnt_nxt = '0;
      w_line_idx_nxt = '0;
      w_cell_nxt     = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_WAIT_KEY;
        end

        S_WAIT_KEY: begin
          if (key_if.key_valid) begin
            if (w_code_in_range && w_cell_empty) begin
              w_cell_nxt  = key_if.key_code;
              w_state_nxt = S_PLACE;
            end else begin
              w_reject_nxt = 1'b1;
            end
          end
        end

        S_PLACE: begin
          w_board_nxt[cell_bits(r_cell) +: 2] = w_mover;
          w_move_cnt_nxt = r_move_cnt + 4'd1;
          w_line_idx_nxt = '0;
          w_state_nxt    = S_CHECK;
        end

        S_CHECK: begin
          if (w_match) begin
            w_result_nxt   = r_turn ? RES_OWIN : RES_XWIN;
            w_win_line_nxt = r_line_idx;
            w_state_nxt    = S_DONE;
          end else if (r_line_idx == 3'd7) begin
            if (r_move_cnt == 4'd9) begin
              w_result_nxt = RES_DRAW;
              w_state_nxt  = S_DONE;
            end else begin
              w_turn_nxt  = ~r_turn;
              w_state_nxt = S_WAIT_KEY;
            end
          end else begin
            w_line_idx_nxt = r_line_idx + 3'd1;
          end
        end

        S_DONE: begin
          w_state_nxt = S_DONE;
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // key_ready is decoded from the state register only, so it carries no
  // combinational path from the inputs.
  assign key_if.key_ready = (r_state == S_WAIT_KEY);
  assign board            = r_board;
  assign turn_o           = r_turn;
  assign result           = r_result;
  assign win_line         = r_win_line;
  assign move_cnt         = r_move_cnt;
  assign reject           = r_reject;

endmodule
